// File: rtl/b200_tx_chdr_framer.sv
// b200_tx_chdr_framer: reframes host TX CHDR packets so tlast matches the header length field.
// Short packets are zero-padded, long ones truncated, illegal lengths dropped; saturating error counters.
module b200_tx_chdr_framer #(
  parameter int MAX_LEN = 8192,
  parameter int CNT_W   = 16
) (
  input  logic             bus_clk,
  input  logic             reset_global,
  input  logic             clear,
  input  logic [63:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [63:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] short_cnt,
  output logic [CNT_W-1:0] long_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  typedef enum logic [2:0] {HDR, BODY, PAD, DRAIN, DROP} state_t;
  state_t state;
  logic [16:0] rem;
  logic [15:0] len;
  logic [16:0] lines;
  logic bad_len, vld, rdy, lst, in_hs, out_hs;
  logic pkt_inc, short_inc, long_inc, drop_inc;
  logic [63:0] dat;
  assign len     = i_tdata[47:32];
  assign lines   = ({1'b0, len} + 17'd7) >> 3;
  assign bad_len = (len < 16'd8) || ({16'd0, len} > 32'(MAX_LEN));
  always_comb begin
    vld = (state == HDR) ? (i_tvalid & ~bad_len) : (state == BODY) ? i_tvalid : (state == PAD);
    rdy = (state == HDR) ? (bad_len | o_tready) : (state == BODY) ? o_tready : (state == DRAIN || state == DROP);
    lst = (state == HDR) ? (lines == 17'd1) : ((state == BODY || state == PAD) && rem == 17'd1);
    dat = (state == HDR || state == BODY) ? i_tdata : 64'd0;
    in_hs  = i_tvalid & rdy;
    out_hs = vld & o_tready;
    pkt_inc   = out_hs & lst;
    short_inc = in_hs & i_tlast & (((state == HDR) & ~bad_len & (lines != 17'd1)) | ((state == BODY) & (rem != 17'd1)));
    long_inc  = in_hs & ~i_tlast & (((state == HDR) & ~bad_len & (lines == 17'd1)) | ((state == BODY) & (rem == 17'd1)));
    drop_inc  = in_hs & i_tlast & (((state == HDR) & bad_len) | (state == DROP));
  end
  // Outputs are forced low combinationally so reset takes effect without waiting for a clock.
  assign o_tvalid = vld & ~reset_global;
  assign i_tready = rdy & ~reset_global;
  assign o_tlast  = lst & vld & ~reset_global;
  assign o_tdata  = reset_global ? 64'd0 : dat;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic inc);
    return clear ? '0 : (inc && !(&c)) ? c + CNT_W'(1) : c;
  endfunction
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      state     <= HDR;
      rem       <= '0;
      pkt_cnt   <= '0;
      short_cnt <= '0;
      long_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      pkt_cnt   <= sat(pkt_cnt, pkt_inc);
      short_cnt <= sat(short_cnt, short_inc);
      long_cnt  <= sat(long_cnt, long_inc);
      drop_cnt  <= sat(drop_cnt, drop_inc);
      case (state)
        HDR: if (in_hs) begin
          if (bad_len) state <= i_tlast ? HDR : DROP;
          else if (lines == 17'd1) state <= i_tlast ? HDR : DRAIN;
          else begin
            rem   <= lines - 17'd1;
            state <= i_tlast ? PAD : BODY;
          end
        end
        BODY: if (in_hs) begin
          rem <= rem - 17'd1;
          if (rem == 17'd1) state <= i_tlast ? HDR : DRAIN;
          else if (i_tlast) state <= PAD;
        end
        PAD: if (out_hs) begin
          rem <= rem - 17'd1;
          if (rem == 17'd1) state <= HDR;
        end
        DRAIN, DROP: if (in_hs && i_tlast) state <= HDR;
        default: state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_b200_tx_chdr_framer.sv
// tb_b200_tx_chdr_framer: directed bench for the TX CHDR framer (pad, truncate, drop, counters, reset).
// A second instance with 4-bit counters exercises saturation.
module tb_b200_tx_chdr_framer;
  logic bus_clk = 0, reset_global = 1, clear = 0;
  logic [63:0] i_tdata = '0;
  logic i_tlast = 0, i_tvalid = 0, o_tready = 1;
  logic i_tready, o_tlast, o_tvalid;
  logic [63:0] o_tdata;
  logic [15:0] pkt_cnt, short_cnt, long_cnt, drop_cnt;
  logic s_i_tready, s_o_tlast, s_o_tvalid;
  logic [63:0] s_o_tdata;
  logic [3:0] s_pkt, s_short, s_long, s_drop;
  int total = 0, bad = 0, n0 = 0, cyc = 0, acc = 0;
  logic rnd = 0;
  logic [64:0] outq[$];

  b200_tx_chdr_framer dut (.bus_clk(bus_clk), .reset_global(reset_global), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .pkt_cnt(pkt_cnt), .short_cnt(short_cnt), .long_cnt(long_cnt), .drop_cnt(drop_cnt));

  b200_tx_chdr_framer #(.CNT_W(4)) sat_dut (.bus_clk(bus_clk), .reset_global(reset_global), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(s_i_tready),
    .o_tdata(s_o_tdata), .o_tlast(s_o_tlast), .o_tvalid(s_o_tvalid), .o_tready(o_tready),
    .pkt_cnt(s_pkt), .short_cnt(s_short), .long_cnt(s_long), .drop_cnt(s_drop));

  always #5 bus_clk = ~bus_clk;

  always @(negedge bus_clk) if (o_tvalid && o_tready) outq.push_back({o_tlast, o_tdata});

  function automatic logic [63:0] hdr(input logic [15:0] len, input logic [31:0] tag);
    return {16'hC0DE, len, tag};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input int idx, input logic [64:0] exp);
    chk(tag, (outq.size() > n0 + idx) ? outq[n0 + idx] : {1'b1, 64'hDEAD_DEAD_DEAD_DEAD}, exp);
  endtask

  task automatic send(input logic [63:0] d, input logic l, output int c);
    logic hs;
    hs = 0;
    c = 0;
    i_tdata = d;
    i_tlast = l;
    i_tvalid = 1;
    for (int k = 0; k < 200 && !hs; k++) begin
      if (rnd) o_tready = 1'($urandom_range(0, 1));
      #3;
      hs = i_tready;
      @(posedge bus_clk);
      #1;
      c++;
    end
    if (!hs) chk("send timeout", {64'd0, hs}, 65'd1);
    i_tvalid = 0;
    i_tlast = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if (rnd) o_tready = 1'($urandom_range(0, 1));
      @(posedge bus_clk);
      #1;
    end
    o_tready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  initial begin
    // Reset with a valid header presented: nothing may leak through.
    i_tvalid = 1;
    i_tdata = hdr(16'd24, 32'h0);
    #3;
    chk("rst o_tvalid", {64'd0, o_tvalid}, 65'd0);
    chk("rst i_tready", {64'd0, i_tready}, 65'd0);
    chk("rst o_tlast", {64'd0, o_tlast}, 65'd0);
    chk("rst o_tdata", {1'b0, o_tdata}, 65'd0);
    chk("rst pkt_cnt", {49'd0, pkt_cnt}, 65'd0);
    @(posedge bus_clk);
    #1;
    i_tvalid = 0;
    reset_global = 0;
    @(posedge bus_clk);
    #1;

    // Legal len=24, three beats, random backpressure.
    rnd = 1;
    n0 = outq.size();
    send(hdr(16'd24, 32'h1), 1'b0, cyc);
    send(64'h1111_2222_3333_4444, 1'b0, cyc);
    send(64'h5555_6666_7777_8888, 1'b1, cyc);
    idle(10);
    chk("t1 size", 65'(outq.size() - n0), 65'd3);
    beat("t1 b0", 0, {1'b0, hdr(16'd24, 32'h1)});
    beat("t1 b1", 1, {1'b0, 64'h1111_2222_3333_4444});
    beat("t1 b2", 2, {1'b1, 64'h5555_6666_7777_8888});
    chk("t1 pkt", {49'd0, pkt_cnt}, 65'd1);
    chk("t1 err", {17'd0, short_cnt, long_cnt, drop_cnt}, 65'd0);

    // len=32 ending after two beats: two zero pad beats follow.
    n0 = outq.size();
    send(hdr(16'd32, 32'h2), 1'b0, cyc);
    send(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, cyc);
    idle(40);
    chk("t2 size", 65'(outq.size() - n0), 65'd4);
    beat("t2 b0", 0, {1'b0, hdr(16'd32, 32'h2)});
    beat("t2 b1", 1, {1'b0, 64'hAAAA_BBBB_CCCC_DDDD});
    beat("t2 b2", 2, 65'd0);
    beat("t2 b3", 3, {1'b1, 64'd0});
    chk("t2 short", {49'd0, short_cnt}, 65'd1);
    chk("t2 pkt", {49'd0, pkt_cnt}, 65'd2);

    // len=16 with five input beats: truncated after two.
    n0 = outq.size();
    send(hdr(16'd16, 32'h3), 1'b0, cyc);
    for (int i = 1; i <= 4; i++) send(64'(i) * 64'h0101_0101_0101_0101, i == 4, cyc);
    idle(10);
    chk("t3 size", 65'(outq.size() - n0), 65'd2);
    beat("t3 b0", 0, {1'b0, hdr(16'd16, 32'h3)});
    beat("t3 b1", 1, {1'b1, 64'h0101_0101_0101_0101});
    chk("t3 long", {49'd0, long_cnt}, 65'd1);
    chk("t3 short", {49'd0, short_cnt}, 65'd1);
    chk("t3 pkt", {49'd0, pkt_cnt}, 65'd3);

    // Illegal lengths dropped while the core is stalled; input never backpressured.
    rnd = 0;
    o_tready = 0;
    n0 = outq.size();
    acc = 0;
    send(hdr(16'd4, 32'h4), 1'b0, cyc); acc += cyc;
    send(64'h1, 1'b0, cyc); acc += cyc;
    send(64'h2, 1'b1, cyc); acc += cyc;
    send(hdr(16'd8200, 32'h5), 1'b0, cyc); acc += cyc;
    send(64'h3, 1'b0, cyc); acc += cyc;
    send(64'h4, 1'b1, cyc); acc += cyc;
    chk("t4 cycles", 65'(acc), 65'd6);
    o_tready = 1;
    idle(2);
    chk("t4 size", 65'(outq.size() - n0), 65'd0);
    chk("t4 drop", {49'd0, drop_cnt}, 65'd2);
    chk("t4 pkt", {49'd0, pkt_cnt}, 65'd3);
    chk("sat pre", {61'd0, s_pkt}, 65'd3);

    // 100 back-to-back single-beat packets, clear pulsed during packet 50.
    n0 = outq.size();
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      clear = (i == 50);
      send(hdr(16'd8, 32'(i)), 1'b1, cyc);
      acc += cyc;
      clear = 0;
      if (i == 49) chk("t5 sat hit", {61'd0, s_pkt}, 65'd15);
      if (i == 50) chk("t5 clear wins", {49'd0, pkt_cnt}, 65'd0);
    end
    idle(2);
    chk("t5 cycles", 65'(acc), 65'd100);
    chk("t5 size", 65'(outq.size() - n0), 65'd100);
    for (int i = 0; i < 100; i += 11) beat("t5 beat", i, {1'b1, hdr(16'd8, 32'(i))});
    chk("t5 pkt", {49'd0, pkt_cnt}, 65'd49);
    chk("t5 drop cleared", {49'd0, drop_cnt}, 65'd0);
    chk("t5 sat hold", {61'd0, s_pkt}, 65'd15);

    // Reset asserted mid-BODY.
    send(hdr(16'd32, 32'h6), 1'b0, cyc);
    send(64'h6666, 1'b0, cyc);
    i_tvalid = 1;
    i_tdata = 64'h7777;
    #2;
    reset_global = 1;
    #1;
    chk("t6 o_tvalid", {64'd0, o_tvalid}, 65'd0);
    chk("t6 o_tdata", {1'b0, o_tdata}, 65'd0);
    chk("t6 i_tready", {64'd0, i_tready}, 65'd0);
    chk("t6 pkt", {49'd0, pkt_cnt}, 65'd0);
    @(posedge bus_clk);
    #1;
    i_tvalid = 0;
    reset_global = 0;
    n0 = outq.size();
    send(hdr(16'd16, 32'h7), 1'b0, cyc);
    send(64'h8888, 1'b1, cyc);
    idle(2);
    chk("t6 size", 65'(outq.size() - n0), 65'd2);
    beat("t6 b0", 0, {1'b0, hdr(16'd16, 32'h7)});
    beat("t6 b1", 1, {1'b1, 64'h8888});
    chk("t6 pkt after", {49'd0, pkt_cnt}, 65'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
